// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 memory-access stage: one req/ack bus transaction per load/store, lane steering and load extension.
// Optional misaligned-access trap compiled in with LSU_MISALIGN_CHECK_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        MemRW,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] dataW,
    output logic [31:0] dataB,
    output logic        stall,
    output logic        done,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_dataB;
    logic        r_misalign;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // funct3[1:0] selects the size; 11 and 10 both fall through to word access.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = dataW;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{dataW[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{dataW[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = dataW;
            end
        endcase
        if (!MemRW) begin
            w_wdata = 32'd0;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_shift = bus_rdata >> {r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_funct3   <= 3'd0;
            r_we       <= 1'b0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_dataB    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_en) begin
                        r_addr   <= addr;
                        r_funct3 <= funct3;
                        r_we     <= MemRW;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_dataB <= w_load;
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_misalign <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall     = ((r_state == S_IDLE) && mem_en) || (r_state == S_REQ);
    assign done      = (r_state == S_DONE);
    assign misalign  = r_misalign;
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = r_we;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;
    assign dataB     = r_dataB;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector-table and scoreboard bench for load_store_unit.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_en;
    logic        MemRW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataB;
    logic        stall;
    logic        done;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .MemRW(MemRW), .funct3(funct3),
        .addr(addr), .dataW(dataW), .dataB(dataB), .stall(stall), .done(done),
        .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_dataB;
    } vec_t;

    vec_t        vt[11];
    vec_t        vx;
    logic [31:0] sb_q[$];
    int          n_chk;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int stalls;
        logic [31:0] e;
        stalls = 0;
        @(negedge clk);
        chk("done_idle", done, 1'b0);
        mem_en = 1'b1; MemRW = v.we; funct3 = v.f3; addr = v.addr; dataW = v.wdat; bus_ack = 1'b0;
        sb_q.push_back(v.e_dataB);
        #1;
        if (stall) stalls++;
        chk("req_idle", bus_req, 1'b0);
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            if (stall) stalls++;
            chk("req", bus_req, 1'b1);
            if (w == 0) begin
                chk("done_req", done, 1'b0);
                chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
                chk("bus_be", bus_be, v.e_be);
                chk("bus_wdata", bus_wdata, v.e_wdata);
                chk("bus_we", bus_we, v.we);
            end
            if (w == v.waits) begin
                bus_ack = 1'b1; bus_rdata = v.rdata;
            end else begin
                bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        chk("done", done, 1'b1);
        chk("stall_done", stall, 1'b0);
        chk("req_done", bus_req, 1'b0);
        chk("misalign", misalign, 1'b0);
        chk("stall_cycles", stalls, v.waits + 2);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("dataB", dataB, e);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; mem_en = 1'b0; MemRW = 1'b0; funct3 = 3'd0; addr = 32'd0;
        dataW = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;

        vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 4'b1111, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'h00000080};
        vt[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h00000080};
        vt[4]  = '{1'b1, 3'b000, 32'h001, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h00000080};
        vt[5]  = '{1'b0, 3'b101, 32'h002, 32'h0,        32'hBEEF0000, 0, 4'b1100, 32'h0,        32'h0000BEEF};
        vt[6]  = '{1'b0, 3'b001, 32'h000, 32'h0,        32'h00008001, 1, 4'b0011, 32'h0,        32'hFFFF8001};
        vt[7]  = '{1'b1, 3'b010, 32'h010, 32'h11223344, 32'h0,        0, 4'b1111, 32'h11223344, 32'hFFFF8001};
        vt[8]  = '{1'b0, 3'b111, 32'h004, 32'h0,        32'hCAFEF00D, 0, 4'b1111, 32'h0,        32'hCAFEF00D};
        vt[9]  = '{1'b1, 3'b000, 32'h003, 32'h0000007E, 32'h0,        0, 4'b1000, 32'h7E7E7E7E, 32'hCAFEF00D};
        vt[10] = '{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 3, 4'b0010, 32'h0,        32'h0000007F};

        @(negedge clk);
        @(negedge clk);
        chk("rst_dataB", dataB, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_be", bus_be, 4'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_stall", stall, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vt[i]);
        end
        @(negedge clk);
        mem_en = 1'b0;
        chk("done_after", done, 1'b0);

        // Reset in the middle of REQ, then an ack that arrives too late.
        @(negedge clk);
        mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        chk("rst_mid_req", bus_req, 1'b1);
        rst_n = 1'b0; mem_en = 1'b0;
        #1;
        chk("rst_mid_req_drop", bus_req, 1'b0);
        chk("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_dataB", dataB, 32'd0);
        chk("rst_mid_be", bus_be, 4'd0);
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h99999999;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_done", done, 1'b0);
        chk("late_ack_req", bus_req, 1'b0);
        chk("late_ack_dataB", dataB, 32'd0);
        @(negedge clk);
        chk("late_ack_done2", done, 1'b0);

        vx = '{1'b0, 3'b010, 32'h008, 32'h0, 32'h12345678, 0, 4'b1111, 32'h0, 32'h12345678};
        run_vec(vx);
        @(negedge clk);
        mem_en = 1'b0;

`ifdef LSU_MISALIGN_CHECK_EN
        @(negedge clk);
        mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'b010; addr = 32'h102;
        #1;
        chk("mis_req0", bus_req, 1'b0);
        @(negedge clk);
        chk("mis_done", done, 1'b1);
        chk("mis_flag", misalign, 1'b1);
        chk("mis_req1", bus_req, 1'b0);
        chk("mis_dataB", dataB, 32'h12345678);
        mem_en = 1'b0;
        @(negedge clk);
        chk("mis_flag_clr", misalign, 1'b0);
        chk("mis_done_clr", done, 1'b0);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
